queen_solution_receiver: RTL and testbench

//  Sink for the N-queens solver's result stream: frame opens on the solver's done pulse,

---
 rtl/queen_solution_receiver.sv | 229 ++++++++++++++++++++++
 tb/tb_queen_solution_receiver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queen_solution_receiver.sv
// Receives one N-queens board per frame, re-checks it pairwise and holds the verdict until acked.
// Optional macro SOLUTION_COUNT_EN adds the sol_count port and its counter of acked legal boards.
module queen_solution_receiver #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 done,
   input  logic                 enable_output,
   input  logic [N-1:0]         row_in,
   input  logic                 result_ack,
   output logic                 rx_ready,
   output logic                 result_valid,
   output logic                 board_ok,
   output logic                 err_onehot,
   output logic                 err_col,
   output logic                 err_diag,
   output logic [IDX_W-1:0]     err_i,
   output logic [IDX_W-1:0]     err_j,
   output logic [N*IDX_W-1:0]   cols_out,
   output logic                 overrun
`ifdef SOLUTION_COUNT_EN
   ,
   output logic [15:0]          sol_count
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_RECEIVE, S_ONEHOT, S_SCAN, S_REPORT} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   row_cnt_q, row_cnt_d;
   logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
   logic [N-1:0]       buf_q [N];
   logic [N-1:0]       buf_d [N];
   logic [IDX_W-1:0]   cols_q [N];
   logic [IDX_W-1:0]   cols_d [N];
   logic               board_ok_q, board_ok_d;
   logic               err_onehot_q, err_onehot_d;
   logic               err_col_q, err_col_d;
   logic               err_diag_q, err_diag_d;
   logic [IDX_W-1:0]   err_i_q, err_i_d, err_j_q, err_j_d;
   logic               overrun_q, overrun_d;
`ifdef SOLUTION_COUNT_EN
   logic [15:0]        sol_cnt_q, sol_cnt_d;
`endif

   logic               bad_found;
   logic [IDX_W-1:0]   bad_row;
   logic [IDX_W-1:0]   ci, cj;
   logic [IDX_W:0]     col_diff, row_diff;

   function automatic logic is_onehot(input logic [N-1:0] v);
      return (v != '0) && ((v & (v - N'(1))) == '0);
   endfunction

   function automatic logic [IDX_W-1:0] encode(input logic [N-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (v[k]) idx = IDX_W'(k);
      end
      return idx;
   endfunction

   always_comb begin
      state_d      = state_q;
      row_cnt_d    = row_cnt_q;
      i_d          = i_q;
      j_d          = j_q;
      buf_d        = buf_q;
      cols_d       = cols_q;
      board_ok_d   = board_ok_q;
      err_onehot_d = err_onehot_q;
      err_col_d    = err_col_q;
      err_diag_d   = err_diag_q;
      err_i_d      = err_i_q;
      err_j_d      = err_j_q;
      overrun_d    = overrun_q;
`ifdef SOLUTION_COUNT_EN
      sol_cnt_d    = sol_cnt_q;
`endif

      // Descending walk so the lowest offending row is the one that sticks.
      bad_found = 1'b0;
      bad_row   = '0;
      for (int r = N - 1; r >= 0; r--) begin
         if (!is_onehot(buf_q[r])) begin
            bad_found = 1'b1;
            bad_row   = IDX_W'(r);
         end
      end

      ci       = cols_q[i_q];
      cj       = cols_q[j_q];
      col_diff = (ci > cj) ? ({1'b0, ci} - {1'b0, cj}) : ({1'b0, cj} - {1'b0, ci});
      row_diff = {1'b0, j_q} - {1'b0, i_q};

      case (state_q)
         S_IDLE: begin
            if (done) begin
               state_d   = S_RECEIVE;
               row_cnt_d = '0;
            end
         end
         S_RECEIVE: begin
            if (done) begin
               row_cnt_d = '0;
            end else if (enable_output) begin
               buf_d[row_cnt_q] = row_in;
               row_cnt_d        = row_cnt_q + IDX_W'(1);
               if (row_cnt_q == IDX_W'(N - 1)) state_d = S_ONEHOT;
            end
         end
         S_ONEHOT: begin
            board_ok_d   = 1'b0;
            err_onehot_d = 1'b0;
            err_col_d    = 1'b0;
            err_diag_d   = 1'b0;
            err_i_d      = '0;
            err_j_d      = '0;
            if (bad_found) begin
               err_onehot_d = 1'b1;
               err_i_d      = bad_row;
               err_j_d      = bad_row;
               state_d      = S_REPORT;
            end else begin
               for (int r = 0; r < N; r++) cols_d[r] = encode(buf_q[r]);
               i_d     = '0;
               j_d     = IDX_W'(1);
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (ci == cj) begin
               err_col_d = 1'b1;
               err_i_d   = i_q;
               err_j_d   = j_q;
               state_d   = S_REPORT;
            end else if (col_diff == row_diff) begin
               err_diag_d = 1'b1;
               err_i_d    = i_q;
               err_j_d    = j_q;
               state_d    = S_REPORT;
            end else if (i_q == IDX_W'(N - 2) && j_q == IDX_W'(N - 1)) begin
               board_ok_d = 1'b1;
               state_d    = S_REPORT;
            end else if (j_q == IDX_W'(N - 1)) begin
               i_d = i_q + IDX_W'(1);
               j_d = i_q + IDX_W'(2);
            end else begin
               j_d = j_q + IDX_W'(1);
            end
         end
         S_REPORT: begin
            // Ack takes priority over a colliding done; the new frame is dropped either way.
            if (result_ack) begin
               state_d   = S_IDLE;
               overrun_d = 1'b0;
`ifdef SOLUTION_COUNT_EN
               if (board_ok_q) sol_cnt_d = sol_cnt_q + 16'd1;
`endif
            end else if (done) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         row_cnt_q    <= '0;
         i_q          <= '0;
         j_q          <= '0;
         board_ok_q   <= 1'b0;
         err_onehot_q <= 1'b0;
         err_col_q    <= 1'b0;
         err_diag_q   <= 1'b0;
         err_i_q      <= '0;
         err_j_q      <= '0;
         overrun_q    <= 1'b0;
`ifdef SOLUTION_COUNT_EN
         sol_cnt_q    <= '0;
`endif
         for (int r = 0; r < N; r++) begin
            buf_q[r]  <= '0;
            cols_q[r] <= '0;
         end
      end else begin
         state_q      <= state_d;
         row_cnt_q    <= row_cnt_d;
         i_q          <= i_d;
         j_q          <= j_d;
         board_ok_q   <= board_ok_d;
         err_onehot_q <= err_onehot_d;
         err_col_q    <= err_col_d;
         err_diag_q   <= err_diag_d;
         err_i_q      <= err_i_d;
         err_j_q      <= err_j_d;
         overrun_q    <= overrun_d;
`ifdef SOLUTION_COUNT_EN
         sol_cnt_q    <= sol_cnt_d;
`endif
         buf_q        <= buf_d;
         cols_q       <= cols_d;
      end
   end

   always_comb begin
      cols_out = '0;
      for (int r = 0; r < N; r++) cols_out[r*IDX_W +: IDX_W] = cols_q[r];
   end

   assign rx_ready     = (state_q == S_IDLE);
   assign result_valid = (state_q == S_REPORT);
   assign board_ok     = board_ok_q;
   assign err_onehot   = err_onehot_q;
   assign err_col      = err_col_q;
   assign err_diag     = err_diag_q;
   assign err_i        = err_i_q;
   assign err_j        = err_j_q;
   assign overrun      = overrun_q;
`ifdef SOLUTION_COUNT_EN
   assign sol_count    = sol_cnt_q;
`endif

endmodule

// File: tb/tb_queen_solution_receiver.sv
// Randomized self-checking bench for queen_solution_receiver against a rule-level board model.
module tb_queen_solution_receiver;
   localparam int N     = 8;
   localparam int IDX_W = 3;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               done = 1'b0;
   logic               enable_output = 1'b0;
   logic [N-1:0]       row_in = '0;
   logic               result_ack = 1'b0;
   logic               rx_ready, result_valid, board_ok;
   logic               err_onehot, err_col, err_diag, overrun;
   logic [IDX_W-1:0]   err_i, err_j;
   logic [N*IDX_W-1:0] cols_out;
`ifdef SOLUTION_COUNT_EN
   logic [15:0]        sol_count;
`endif

   queen_solution_receiver #(.N(N), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset_n(reset_n), .done(done), .enable_output(enable_output),
      .row_in(row_in), .result_ack(result_ack), .rx_ready(rx_ready),
      .result_valid(result_valid), .board_ok(board_ok), .err_onehot(err_onehot),
      .err_col(err_col), .err_diag(err_diag), .err_i(err_i), .err_j(err_j),
      .cols_out(cols_out), .overrun(overrun)
`ifdef SOLUTION_COUNT_EN
      , .sol_count(sol_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [N-1:0]       frame [N];
   logic               m_ok, m_eo, m_ec, m_ed;
   int                 m_ei, m_ej, m_lat;
   logic [N*IDX_W-1:0] m_cols;
   int                 exp_sol = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Board rules: lowest non-one-hot row, else first clashing pair in (i,j) order.
   // m_lat counts clock edges from the edge that captures the last beat until result_valid.
   task automatic model();
      int  col [N];
      int  k;
      logic found;
      m_ok = 0; m_eo = 0; m_ec = 0; m_ed = 0; m_ei = 0; m_ej = 0; m_lat = 1; m_cols = '0;
      for (int r = 0; r < N; r++) begin
         if (!m_eo && $countones(frame[r]) != 1) begin
            m_eo = 1; m_ei = r; m_ej = r;
         end
      end
      if (!m_eo) begin
         for (int r = 0; r < N; r++) begin
            col[r] = 0;
            for (int b = 0; b < N; b++) if (frame[r][b]) col[r] = b;
            m_cols[r*IDX_W +: IDX_W] = IDX_W'(col[r]);
         end
         k = 0;
         found = 0;
         for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
               if (!found) begin
                  k++;
                  if (col[i] == col[j]) begin
                     found = 1; m_ec = 1; m_ei = i; m_ej = j;
                  end else if ((col[i] > col[j] ? col[i] - col[j] : col[j] - col[i]) == j - i) begin
                     found = 1; m_ed = 1; m_ei = i; m_ej = j;
                  end
               end
            end
         end
         m_ok  = !found;
         m_lat = 1 + k;
      end
   endtask

   task automatic set_cols(input int c0, c1, c2, c3, c4, c5, c6, c7);
      int c [N];
      c = '{c0, c1, c2, c3, c4, c5, c6, c7};
      for (int r = 0; r < N; r++) begin
         frame[r] = '0;
         frame[r][c[r]] = 1'b1;
      end
   endtask

   task automatic send_beats(input int nbeats);
      for (int r = 0; r < nbeats; r++) begin
         enable_output = 1'b1;
         row_in = frame[r];
         tick();
      end
      enable_output = 1'b0;
      row_in = '0;
   endtask

   task automatic send_frame();
      done = 1'b1;
      tick();
      done = 1'b0;
      send_beats(N);
   endtask

   task automatic check_result(input string tag);
      int cyc = 0;
      while (!result_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk({tag, ".latency"}, cyc, m_lat);
      chk({tag, ".valid"}, result_valid, 1);
      chk({tag, ".rx_ready"}, rx_ready, 0);
      chk({tag, ".board_ok"}, board_ok, m_ok);
      chk({tag, ".err_onehot"}, err_onehot, m_eo);
      chk({tag, ".err_col"}, err_col, m_ec);
      chk({tag, ".err_diag"}, err_diag, m_ed);
      chk({tag, ".err_i"}, err_i, m_ei);
      chk({tag, ".err_j"}, err_j, m_ej);
      if (!m_eo) chk({tag, ".cols_out"}, cols_out, m_cols);
   endtask

   task automatic do_ack(input string tag);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      if (m_ok) exp_sol++;
      chk({tag, ".ack_valid"}, result_valid, 0);
      chk({tag, ".ack_ready"}, rx_ready, 1);
      chk({tag, ".ack_overrun"}, overrun, 0);
      chk({tag, ".hold_ok"}, board_ok, m_ok);
`ifdef SOLUTION_COUNT_EN
      chk({tag, ".sol_count"}, sol_count, exp_sol & 16'hFFFF);
`endif
   endtask

   task automatic run_frame(input string tag);
      model();
      send_frame();
      check_result(tag);
      do_ack(tag);
   endtask

   task automatic random_frame();
      int perm [N];
      int t, s, sel;
      for (int r = 0; r < N; r++) perm[r] = r;
      for (int r = N - 1; r > 0; r--) begin
         s = int'($urandom_range(0, r));
         t = perm[r]; perm[r] = perm[s]; perm[s] = t;
      end
      sel = int'($urandom_range(0, 3));
      case (sel)
         0: set_cols(perm[0], perm[1], perm[2], perm[3], perm[4], perm[5], perm[6], perm[7]);
         1: begin
            if ($urandom_range(0, 1) == 0) set_cols(0, 4, 7, 5, 2, 6, 1, 3);
            else set_cols(0, 5, 7, 2, 6, 3, 1, 4);
            if ($urandom_range(0, 1) == 1)
               for (int r = 0; r < N; r++) frame[r] = {<<{frame[r]}};
            if ($urandom_range(0, 1) == 1)
               for (int r = 0; r < N / 2; r++) begin
                  row_in = frame[r]; frame[r] = frame[N-1-r]; frame[N-1-r] = row_in;
               end
            row_in = '0;
         end
         2: for (int r = 0; r < N; r++) frame[r] = N'($urandom);
         default: begin
            set_cols(perm[0], perm[1], perm[2], perm[3], perm[4], perm[5], perm[6], perm[7]);
            s = int'($urandom_range(0, N - 1));
            if ($urandom_range(0, 1) == 0) frame[s] = '0;
            else frame[s] = frame[s] | (N'(1) << $urandom_range(0, N - 1));
         end
      endcase
   endtask

   initial begin
      tick();
      tick();
      chk("rst.rx_ready", rx_ready, 1);
      chk("rst.valid", result_valid, 0);
      chk("rst.flags", {board_ok, err_onehot, err_col, err_diag, overrun}, 0);
      chk("rst.idx", {err_i, err_j}, 0);
      chk("rst.cols", cols_out, 0);
`ifdef SOLUTION_COUNT_EN
      chk("rst.sol_count", sol_count, 0);
`endif
      reset_n = 1'b1;
      tick();

      set_cols(0, 1, 2, 3, 4, 5, 6, 7);
      send_beats(N);
      tick();
      chk("nodone.rx_ready", rx_ready, 1);
      chk("nodone.valid", result_valid, 0);

      set_cols(0, 4, 7, 5, 2, 6, 1, 3);
      run_frame("legal");
      for (int r = 0; r < N; r++) frame[r] = 8'h01;
      run_frame("allcol");
      for (int r = 0; r < N; r++) frame[r] = N'(1) << r;
      run_frame("maindiag");
      frame[3] = 8'h00;
      run_frame("row3zero");

      // Asynchronous reset mid-frame, asserted between clock edges.
      set_cols(0, 0, 1, 2, 3, 4, 5, 6);
      run_frame("preclash");
      done = 1'b1;
      tick();
      done = 1'b0;
      send_beats(4);
      #2 reset_n = 1'b0;
      #1;
      exp_sol = 0;
      chk("arst.rx_ready", rx_ready, 1);
      chk("arst.valid", result_valid, 0);
      chk("arst.flags", {board_ok, err_onehot, err_col, err_diag, overrun}, 0);
      chk("arst.idx_cols", {err_i, err_j, cols_out}, 0);
      tick();
      reset_n = 1'b1;
      set_cols(0, 5, 7, 2, 6, 3, 1, 4);
      run_frame("postrst");

      // done after 3 beats restarts the frame; done in REPORT raises overrun.
      set_cols(0, 4, 7, 5, 2, 6, 1, 3);
      model();
      done = 1'b1;
      tick();
      done = 1'b0;
      send_beats(3);
      send_frame();
      check_result("restart");
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("ovr.overrun", overrun, 1);
      chk("ovr.valid", result_valid, 1);
      do_ack("ovr");

      set_cols(0, 2, 4, 6, 1, 3, 5, 7);
      model();
      send_frame();
      check_result("ackdone");
      done = 1'b1;
      result_ack = 1'b1;
      tick();
      done = 1'b0;
      result_ack = 1'b0;
      if (m_ok) exp_sol++;
      chk("ackdone.overrun", overrun, 0);
      chk("ackdone.valid", result_valid, 0);
      tick();
      tick();
      chk("ackdone.dropped", rx_ready, 1);

      for (int n = 0; n < 60; n++) begin
         random_frame();
         run_frame("rand");
      end

`ifdef SOLUTION_COUNT_EN
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      exp_sol = 0;
      set_cols(0, 4, 7, 5, 2, 6, 1, 3);
      run_frame("cnt1");
      set_cols(0, 1, 2, 3, 4, 5, 6, 7);
      run_frame("cnt2");
      set_cols(0, 5, 7, 2, 6, 3, 1, 4);
      run_frame("cnt3");
      chk("cnt.total", sol_count, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
